// File: rtl/std_ram_pkg.sv
// Shared constants and helpers for the std_* RAM family.
package std_ram_pkg;

  localparam int BYTE_W = 8;

  // Number of byte-enable bits needed for a data word of width dw.
  function automatic int be_width(input int dw);
    return dw / BYTE_W;
  endfunction

endpackage

// File: rtl/std_tpram_core.sv
// Two-port storage array: byte-masked synchronous write, registered read.
// Reads are read-first: a same-cycle write lands after the read captures the old word.
module std_tpram_core
  import std_ram_pkg::*;
#(
  parameter int DW    = 144,
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH),
  parameter int BW    = be_width(DW)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [BW-1:0] wbe,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];

  logic waddr_ok;
  logic raddr_ok;

  assign waddr_ok = ({1'b0, waddr} < DEPTH_W);
  assign raddr_ok = ({1'b0, raddr} < DEPTH_W);

  // NOTE: the array and its read register carry no reset; clearing a RAM
  // needs a write port per word and defeats mapping onto memory macros.
  always_ff @(posedge clk) begin
    if (we && waddr_ok) begin
      for (int b = 0; b < BW; b++) begin
        if (wbe[b]) mem[waddr][b*BYTE_W +: BYTE_W] <= wdata[b*BYTE_W +: BYTE_W];
      end
    end
    if (re && raddr_ok) rdata <= mem[raddr];
  end

endmodule

// File: rtl/std_tpram_byp.sv
// Two-port RAM wrapper: collision bypass, out-of-range handling, optional
// output register and RVALID generation around std_tpram_core.
module std_tpram_byp
  import std_ram_pkg::*;
#(
  parameter int DW      = 144,
  parameter int DEPTH   = 64,
  parameter int AW      = $clog2(DEPTH),
  parameter int BYPASS  = 1,
  parameter int OUT_REG = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    RCEB,
  input  logic [AW-1:0]           RADDR,
  output logic [DW-1:0]           RDATA,
  output logic                    RVALID,
  input  logic                    WCEB,
  input  logic [AW-1:0]           WADDR,
  input  logic [DW-1:0]           WDATA,
  input  logic [be_width(DW)-1:0] WBEB
);

  localparam int          BW      = be_width(DW);
  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

  logic          we;
  logic          re;
  logic [BW-1:0] wbe;
  logic          hit_d;
  logic          oob_d;
  logic [DW-1:0] core_q;

  // Requests presented during reset never reach the array.
  assign we    = rst_n & ~WCEB;
  assign re    = rst_n & ~RCEB;
  assign wbe   = ~WBEB;
  assign oob_d = ({1'b0, RADDR} >= DEPTH_W);
  // A write with no enabled bytes changes nothing, so it is not a collision.
  assign hit_d = (BYPASS != 0) && we && re && (WADDR == RADDR) && (|wbe);

  std_tpram_core #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (AW),
    .BW    (BW)
  ) u_core (
    .clk   (clk),
    .we    (we),
    .waddr (WADDR),
    .wdata (WDATA),
    .wbe   (wbe),
    .re    (re),
    .raddr (RADDR),
    .rdata (core_q)
  );

  // Read stage 1: tracks the read the core is returning this cycle.
  logic          rv1;
  logic          oob1;
  logic          hit1;
  logic [DW-1:0] bdata1;
  logic [BW-1:0] bmask1;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rv1    <= 1'b0;
      oob1   <= 1'b0;
      hit1   <= 1'b0;
      bdata1 <= '0;
      bmask1 <= '0;
    end else begin
      rv1  <= re;
      oob1 <= re & oob_d;
      hit1 <= hit_d;
      if (hit_d) begin
        bdata1 <= WDATA;
        bmask1 <= wbe;
      end
    end
  end

  logic [DW-1:0] mask_bits;
  logic [DW-1:0] merged;

  // NOTE: every output of this block gets a default first, so no path
  // through it can leave a value unassigned and infer a latch.
  always_comb begin
    mask_bits = '0;
    merged    = core_q;
    for (int b = 0; b < BW; b++) begin
      mask_bits[b*BYTE_W +: BYTE_W] = {BYTE_W{bmask1[b]}};
    end
    if (oob1) begin
      merged = '0;
    end else if (hit1) begin
      merged = (core_q & ~mask_bits) | (bdata1 & mask_bits);
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DW-1:0] out_q;
      logic          rv_q;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          out_q <= '0;
          rv_q  <= 1'b0;
        end else begin
          rv_q <= rv1;
          if (rv1) out_q <= merged;
        end
      end

      assign RDATA  = out_q;
      assign RVALID = rv_q;
    end else begin : g_out_comb
      // Holds the last delivered word so RDATA stays put between reads.
      logic [DW-1:0] hold_q;

      always_ff @(posedge clk) begin
        if (!rst_n)   hold_q <= '0;
        else if (rv1) hold_q <= merged;
      end

      assign RDATA  = rv1 ? merged : hold_q;
      assign RVALID = rv1;
    end
  endgenerate

endmodule

// File: tb/tb_std_tpram_byp.sv
// Self-checking bench: two instances (write-first/no output reg, read-first/output reg)
// driven identically and compared against a word-level memory model.
module tb_std_tpram_byp;

  localparam int DW    = 144;
  localparam int DEPTH = 48;
  localparam int AW    = 6;
  localparam int BW    = DW / 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          RCEB;
  logic [AW-1:0] RADDR;
  logic          WCEB;
  logic [AW-1:0] WADDR;
  logic [DW-1:0] WDATA;
  logic [BW-1:0] WBEB;
  logic [DW-1:0] rdata_a, rdata_b;
  logic          rvalid_a, rvalid_b;

  always #5 clk = ~clk;

  std_tpram_byp #(.DW(DW), .DEPTH(DEPTH), .AW(AW), .BYPASS(1), .OUT_REG(0)) u_a (
    .clk(clk), .rst_n(rst_n), .RCEB(RCEB), .RADDR(RADDR), .RDATA(rdata_a), .RVALID(rvalid_a),
    .WCEB(WCEB), .WADDR(WADDR), .WDATA(WDATA), .WBEB(WBEB)
  );

  std_tpram_byp #(.DW(DW), .DEPTH(DEPTH), .AW(AW), .BYPASS(0), .OUT_REG(1)) u_b (
    .clk(clk), .rst_n(rst_n), .RCEB(RCEB), .RADDR(RADDR), .RDATA(rdata_b), .RVALID(rvalid_b),
    .WCEB(WCEB), .WADDR(WADDR), .WDATA(WDATA), .WBEB(WBEB)
  );

  // Reference model: word array plus per-instance queues of reads awaiting delivery.
  typedef struct {
    int            due;
    logic [DW-1:0] d;
  } rd_t;

  logic [DW-1:0] mem_m [DEPTH];
  rd_t           q_a[$];
  rd_t           q_b[$];
  logic [DW-1:0] last_a, last_b;
  int            cyc;
  int            n_chk;
  int            n_pass;

  function automatic logic [DW-1:0] apply_bytes(input logic [DW-1:0] old,
                                                 input logic [DW-1:0] nw,
                                                 input logic [BW-1:0] wbeb);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < BW; b++) begin
      if (!wbeb[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int b = 0; b < BW; b++) w[b*8 +: 8] = 8'($urandom);
    return w;
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk = n_chk + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
  endtask

  task automatic step(input logic rce, input logic [AW-1:0] ra,
                      input logic wce, input logic [AW-1:0] wa,
                      input logic [DW-1:0] wd, input logic [BW-1:0] wb,
                      input logic rs);
    logic [DW-1:0] old;
    logic [DW-1:0] nw;
    logic          ev_a, ev_b;
    rst_n = rs; RCEB = rce; RADDR = ra; WCEB = wce; WADDR = wa; WDATA = wd; WBEB = wb;
    @(posedge clk);
    cyc = cyc + 1;
    if (!rs) begin
      q_a.delete(); q_b.delete();
      last_a = '0; last_b = '0;
    end else begin
      if (!rce) begin
        old = (int'(ra) < DEPTH) ? mem_m[ra] : '0;
        nw  = old;
        if (!wce && wa == ra && int'(ra) < DEPTH) nw = apply_bytes(old, wd, wb);
        q_a.push_back('{due: cyc,     d: nw});
        q_b.push_back('{due: cyc + 1, d: old});
      end
      if (!wce && int'(wa) < DEPTH) mem_m[wa] = apply_bytes(mem_m[wa], wd, wb);
    end
    #1;
    ev_a = (q_a.size() > 0) && (q_a[0].due == cyc);
    ev_b = (q_b.size() > 0) && (q_b[0].due == cyc);
    if (ev_a) last_a = q_a.pop_front().d;
    if (ev_b) last_b = q_b.pop_front().d;
    check("a_rvalid", DW'(rvalid_a), DW'(ev_a));
    check("a_rdata",  rdata_a, last_a);
    check("b_rvalid", DW'(rvalid_b), DW'(ev_b));
    check("b_rdata",  rdata_b, last_b);
  endtask

  task automatic idle();
    step(1'b1, '0, 1'b1, '0, '0, '1, 1'b1);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] wb);
    step(1'b1, '0, 1'b0, a, d, wb, 1'b1);
  endtask

  task automatic rd(input logic [AW-1:0] a);
    step(1'b0, a, 1'b1, '0, '0, '1, 1'b1);
  endtask

  initial begin
    logic [AW-1:0] ra, wa;
    n_chk = 0; n_pass = 0; cyc = 0;
    last_a = '0; last_b = '0;
    rst_n = 1'b0; RCEB = 1'b1; WCEB = 1'b1; RADDR = '0; WADDR = '0; WDATA = '0; WBEB = '1;

    // Reset: outputs clear.
    repeat (3) step(1'b1, '0, 1'b1, '0, '0, '1, 1'b0);
    idle();

    // Fill every valid word so the model has no unknown contents.
    for (int a = 0; a < DEPTH; a++) wr(AW'(a), rand_word(), '0);

    // Write then read next cycle.
    wr(6'd5, {BW{8'hAA}}, '0);
    rd(6'd5);
    idle();
    check("aa_a_direct", rdata_a, {BW{8'hAA}});
    idle();
    check("aa_b_direct", rdata_b, {BW{8'hAA}});

    // Same-cycle collision with only byte 0 enabled.
    wr(6'd7, {BW{8'h11}}, '0);
    step(1'b0, 6'd7, 1'b0, 6'd7, {BW{8'hFF}}, {{(BW-1){1'b1}}, 1'b0}, 1'b1);
    check("coll_a_direct", rdata_a, {{(BW-1){8'h11}}, 8'hFF});
    idle();
    check("coll_b_direct", rdata_b, {BW{8'h11}});
    rd(6'd7);
    idle(); idle();

    // Back-to-back reads, then hold.
    rd(6'd0); rd(6'd1); rd(6'd2); rd(6'd3);
    idle(); idle(); idle();

    // Out-of-range write dropped, out-of-range read returns zero.
    wr(6'd50, rand_word(), '0);
    rd(6'd50);
    check("oob_a_direct", rdata_a, '0);
    rd(6'd47);
    idle(); idle();

    // Write with no byte enables leaves the word alone, also on collision.
    wr(6'd9, {BW{8'h22}}, '0);
    wr(6'd9, rand_word(), '1);
    step(1'b0, 6'd9, 1'b0, 6'd9, rand_word(), '1, 1'b1);
    rd(6'd9);
    idle(); idle();

    // Read in flight when reset asserts; requests during reset ignored.
    rd(6'd3);
    step(1'b0, 6'd3, 1'b0, 6'd3, rand_word(), '0, 1'b0);
    step(1'b0, 6'd4, 1'b0, 6'd3, rand_word(), '0, 1'b0);
    idle(); idle();
    rd(6'd3);
    idle(); idle();

    // Randomized traffic with frequent collisions and some out-of-range addresses.
    for (int i = 0; i < 400; i++) begin
      ra = AW'($urandom_range(0, 52));
      wa = ($urandom_range(0, 3) == 0) ? ra : AW'($urandom_range(0, 63));
      step(1'($urandom_range(0, 2) == 0), ra,
           1'($urandom_range(0, 1)), wa, rand_word(), BW'($urandom), 1'b1);
    end

    // Randomized back-to-back reads.
    for (int i = 0; i < 40; i++) rd(AW'($urandom_range(0, DEPTH - 1)));
    idle(); idle(); idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
